// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if
// Bundles the two handshakes of the instruction-fetch prefetch stage:
//   - instruction SRAM request/response bus (req/addr out, addr_ok/data_ok/rdata in)
//   - fetch-to-decode handshake (valid/bus out, allowin in)
// Modports:
//   master : the prefetch stage side
//   slave  : the memory / decode side (used by the testbench)
interface if_prefetch_stage_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [79:0] if_to_id_bus;

  modport master (
    output inst_sram_req,
    output inst_sram_addr,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    input  id_allowin,
    output if_to_id_valid,
    output if_to_id_bus
  );

  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    output id_allowin,
    input  if_to_id_valid,
    input  if_to_id_bus
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage
// Prefetching instruction-fetch stage. Issues in-order fetch requests to the
// instruction SRAM, remembers the PC of every accepted request, and queues the
// returned instructions for the decode stage. Redirects (exception, exception
// return, branch) flush everything and drop responses still in flight.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   br_taken/br_target    : branch redirect
//   ertn_flush/ex_ra      : exception-return redirect
//   wb_ex/ex_entry        : exception redirect (highest priority)
//   bus (master)          : SRAM request/response and decode handshake
//   if_to_id_bus layout   : {pc[31:0], inst[31:0], ex, ex_code[14:0]}
// Optional feature: define IF_ADEF_EN to raise an address-error fetch
// exception (ex_code 15'h0008) for misaligned fetch PCs instead of fetching.
module if_prefetch_stage #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] PC_RESET = 32'h1C000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ertn_flush,
  input  logic [31:0] ex_ra,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  if_prefetch_stage_if.master bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] q_count;
  logic [PW-1:0] q_wr, q_rd, pf_wr, pf_rd;
  logic [79:0]   q_mem  [QDEPTH];
  logic [31:0]   pf_mem [QDEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] credit_used;
  logic          has_credit;
  logic          pc_misaligned;
  logic          adef_push;
  logic          accept;
  logic          resp_take;
  logic          resp_live;
  logic          push;
  logic          pop;
  logic [79:0]   push_entry;
  logic [CW-1:0] redirect_discard;

  // Redirect selection: exception beats exception return beats branch.
  always_comb begin
    redirect    = wb_ex | ertn_flush | br_taken;
    redirect_pc = br_target;
    if (wb_ex)
      redirect_pc = ex_entry;
    else if (ertn_flush)
      redirect_pc = ex_ra;
  end

  // Every issued request reserves a queue slot until its instruction leaves,
  // and dropped responses still hold a slot until they arrive, so a
  // non-discarded response always finds room in the queue.
  assign credit_used = SW'(outstanding) + SW'(q_count) + SW'(discard);
  assign has_credit  = credit_used < SW'(QDEPTH);

`ifdef IF_ADEF_EN
  logic adef_sent;

  // A misaligned PC never goes to memory. Once every earlier request has
  // drained, one exception entry is queued and fetching halts until the
  // exception redirect arrives.
  assign pc_misaligned = fetch_pc[1:0] != 2'b00;
  assign adef_push     = !reset && !redirect && pc_misaligned && !adef_sent &&
                         (outstanding == '0) && (discard == '0) &&
                         (q_count < CW'(QDEPTH));

  always_ff @(posedge clk) begin
    if (reset || redirect)
      adef_sent <= 1'b0;
    else if (adef_push)
      adef_sent <= 1'b1;
  end
`else
  assign pc_misaligned = 1'b0;
  assign adef_push     = 1'b0;
`endif

  assign bus.inst_sram_req  = !reset && has_credit && !pc_misaligned;
  assign bus.inst_sram_addr = fetch_pc;
  assign accept             = bus.inst_sram_req && bus.inst_sram_addr_ok;

  // A response is only meaningful if something is actually in flight; this
  // keeps a stray data_ok from corrupting the counters.
  assign resp_live = bus.inst_sram_data_ok && ((outstanding != '0) || (discard != '0));
  assign resp_take = bus.inst_sram_data_ok && !redirect && (discard == '0) &&
                     (outstanding != '0);

  // Everything still in flight after this cycle becomes garbage on a redirect,
  // including a request accepted now; a response arriving now is already gone.
  assign redirect_discard = outstanding + discard + CW'(accept) - CW'(resp_live);

  assign push       = resp_take || adef_push;
  assign push_entry = adef_push ? {fetch_pc, 32'h0, 1'b1, 15'h0008}
                                : {pf_mem[pf_rd], bus.inst_sram_rdata, 1'b0, 15'h0000};

  assign bus.if_to_id_valid = !reset && (q_count != '0);
  assign bus.if_to_id_bus   = q_mem[q_rd];
  assign pop                = bus.if_to_id_valid && bus.id_allowin;

  // Fetch PC, in-flight bookkeeping and the instruction queue. Responses are
  // matched to PCs purely by order, so the PC FIFO pops on every kept response.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= PC_RESET;
      outstanding <= '0;
      discard     <= '0;
      q_count     <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      outstanding <= '0;
      discard     <= redirect_discard;
      q_count     <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      pf_wr       <= '0;
      pf_rd       <= '0;
    end else begin
      if (accept) begin
        pf_mem[pf_wr] <= fetch_pc;
        pf_wr         <= pf_wr + PW'(1);
        fetch_pc      <= fetch_pc + 32'd4;
      end
      if (bus.inst_sram_data_ok) begin
        if (discard != '0)
          discard <= discard - CW'(1);
        else if (outstanding != '0)
          pf_rd <= pf_rd + PW'(1);
      end
      outstanding <= outstanding + CW'(accept) - CW'(resp_take);
      if (push) begin
        q_mem[q_wr] <= push_entry;
        q_wr        <= q_wr + PW'(1);
      end
      if (pop)
        q_rd <= q_rd + PW'(1);
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

endmodule
